// File: rtl/note_phase_accumulator_if.sv
// Voice bus for note_phase_accumulator: note commands, the sample strobe,
// the frequency-step table loop (table_idx out, freq_step back) and the
// phase stream toward the waveform stage.
interface note_phase_accumulator_if #(
  parameter int PHASE_WIDTH = 24
);
  logic                   sample_tick;
  logic                   note_on;
  logic                   note_off;
  logic [6:0]             note_idx;
  logic [PHASE_WIDTH-1:0] freq_step;
  logic [6:0]             table_idx;
  logic [PHASE_WIDTH-1:0] phase;
  logic                   phase_valid;
  logic                   wrap;
  logic                   gate;
  logic                   active;

  // Controller side: issues notes and strobes, supplies the table step.
  modport master (
    output sample_tick, note_on, note_off, note_idx, freq_step,
    input  table_idx, phase, phase_valid, wrap, gate, active
  );

  // Accumulator side.
  modport slave (
    input  sample_tick, note_on, note_off, note_idx, freq_step,
    output table_idx, phase, phase_valid, wrap, gate, active
  );
endinterface

// File: rtl/note_phase_accumulator.sv
// Per-voice phase accumulator. Registers the note index for the external
// step table, advances the phase once per sample strobe with optional
// portamento glide, and on release runs until the next phase wrap so the
// waveform stage sees a click-free stop.
module note_phase_accumulator #(
  parameter int PHASE_WIDTH = 24,
  parameter int GLIDE_SHIFT = 0
) (
  input logic                     clk,
  input logic                     rst_n,
  note_phase_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [6:0]             table_idx_q, table_idx_d;
  logic [PHASE_WIDTH-1:0] cur_step_q, cur_step_d;
  logic                   snap_q, snap_d;
  logic                   phase_valid_q, phase_valid_d;
  logic                   wrap_q, wrap_d;

  logic signed [PHASE_WIDTH:0] diff;
  logic signed [PHASE_WIDTH:0] delta;
  logic [PHASE_WIDTH-1:0]      next_step;
  logic [PHASE_WIDTH:0]        sum;

  // Step for this tick: jump straight to the table value on a fresh note
  // or when glide is off; otherwise close a 2^-GLIDE_SHIFT fraction of the
  // gap. The arithmetic shift never grows |diff|, so the step cannot
  // overshoot, and a zero delta snaps onto the target to finish the glide.
  always_comb begin
    diff  = $signed({1'b0, bus.freq_step}) - $signed({1'b0, cur_step_q});
    delta = diff >>> GLIDE_SHIFT;
    if (snap_q || (GLIDE_SHIFT == 0) || (delta == '0)) begin
      next_step = bus.freq_step;
    end else begin
      next_step = cur_step_q + delta[PHASE_WIDTH-1:0];
    end
    sum = {1'b0, phase_q} + {1'b0, next_step};
  end

  // Next-state logic: the tick is evaluated against the pre-command state,
  // then a note command overrides state, table index and snap.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    phase_d       = phase_q;
    table_idx_d   = table_idx_q;
    cur_step_d    = cur_step_q;
    snap_d        = snap_q;
    phase_valid_d = bus.sample_tick;
    wrap_d        = 1'b0;

    if (bus.sample_tick) begin
      case (state_q)
        ST_RUN: begin
          phase_d    = sum[PHASE_WIDTH-1:0];
          cur_step_d = next_step;
          snap_d     = 1'b0;
          wrap_d     = sum[PHASE_WIDTH];
        end
        ST_STOP: begin
          if (sum[PHASE_WIDTH]) begin
            // Release completes exactly at the zero crossing of the phase.
            phase_d    = '0;
            cur_step_d = '0;
            state_d    = ST_IDLE;
            wrap_d     = 1'b1;
          end else begin
            phase_d    = sum[PHASE_WIDTH-1:0];
            cur_step_d = next_step;
            snap_d     = 1'b0;
          end
        end
        default: begin
          phase_d = '0;
        end
      endcase
    end

    if (bus.note_on) begin
      // note_on takes priority over a simultaneous note_off.
      table_idx_d = bus.note_idx;
      state_d     = ST_RUN;
      if (state_q == ST_IDLE) begin
        phase_d = '0;
        snap_d  = 1'b1;
      end
    end else if (bus.note_off && (state_q == ST_RUN)) begin
      state_d = ST_STOP;
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      table_idx_q   <= '0;
      cur_step_q    <= '0;
      snap_q        <= 1'b0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // values from before this edge, independent of statement order.
      state_q       <= state_d;
      phase_q       <= phase_d;
      table_idx_q   <= table_idx_d;
      cur_step_q    <= cur_step_d;
      snap_q        <= snap_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
    end
  end

  assign bus.table_idx   = table_idx_q;
  assign bus.phase       = phase_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.wrap        = wrap_q;
  assign bus.gate        = (state_q == ST_RUN);
  assign bus.active      = (state_q != ST_IDLE);

endmodule

// File: doc/note_phase_accumulator.md
# note_phase_accumulator

Per-voice phase accumulator sitting directly downstream of the combinational frequency-step table. It registers the requested note index and drives it to the table. It reads the returned 24-bit frequency step and advances a phase register once per sample strobe, with optional portamento glide. On note-off it keeps running until the next phase wrap before going idle, giving a click-free release to the waveform stage that consumes `phase`.

## Interface
- `PHASE_WIDTH`, 24: phase and step width. Must equal the table output width.
- `GLIDE_SHIFT`, 0: glide coefficient as a right-shift amount. 0 means instant step change.
- `clk` in 1: system clock. All state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sample_tick` in 1: one-cycle strobe at sample rate. Back-to-back strobes are legal.
- `note_on` in 1: one-cycle pulse. Starts or retriggers the voice with `note_idx`.
- `note_off` in 1: one-cycle pulse. Requests release.
- `note_idx` in 7: note number, sampled only when `note_on`=1.
- `freq_step` in PHASE_WIDTH: step from the table, combinational from `table_idx`.
- `table_idx` out 7: registered note index driving the table.
- `phase` out PHASE_WIDTH: current phase.
- `phase_valid` out 1: one-cycle pulse, cycle after every accepted `sample_tick`.
- `wrap` out 1: pulses with `phase_valid` when that update overflowed.
- `gate` out 1: high from note-on until note-off.
- `active` out 1: high in RUN or STOP.

## Operation
States and reset:
- States: IDLE, RUN, STOP.
- Reset values: state IDLE, `phase` 0, `table_idx` 0, internal `cur_step` 0, `snap` 0. `gate`, `active`, `phase_valid` and `wrap` are 0.

Commands:
- **`note_on` in any state:** `table_idx`<=`note_idx`, state<=RUN, `gate`<=1.
  - From IDLE: also `phase`<=0 and `snap`<=1.
  - From RUN or STOP (retrigger): phase is kept and the step glides from `cur_step`.
- **`note_off`:**
  - In RUN: state<=STOP, `gate`<=0.
  - Ignored in IDLE and STOP.
  - If `note_on` and `note_off` arrive in the same cycle, `note_on` wins and `note_off` is dropped.

Step selection per tick:
- `next_step` = `freq_step` if `snap`=1 or `GLIDE_SHIFT`=0.
- Otherwise: `diff` = `freq_step` − `cur_step` as a signed (PHASE_WIDTH+1)-bit value, `delta` = `diff` >>> `GLIDE_SHIFT` (arithmetic shift).
  - `next_step` = `freq_step` if `delta`==0, else `cur_step`+`delta`.
  - The result never overshoots the target.

`sample_tick` by state:
- **RUN:** `{carry, phase}` <= `phase` + `next_step` (PHASE_WIDTH+1 bits). Then `cur_step`<=`next_step`, `snap`<=0, `wrap`<=`carry`. The phase wraps modulo 2^PHASE_WIDTH.
- **STOP:** same sum.
  - If `carry`=1: `phase`<=0, `cur_step`<=0, state<=IDLE, `wrap`<=1.
  - Else: the sum is stored as in RUN.
- **IDLE:** `phase` stays 0, `wrap`<=0.
- In every state, `phase_valid`<=1 for exactly one cycle, so the sample stream stays continuous.

## Timing
- `note_on` at edge t updates `table_idx` at t+1. `freq_step` is valid during cycle t+1, so a `sample_tick` at t+1 or later uses the new note.
- A `sample_tick` coincident with `note_on` is processed with the pre-command state: in IDLE it gives no advance.
- `phase`, `wrap` and `phase_valid` update on the edge that samples `sample_tick`, giving a latency of 1 cycle.
- `gate` and `active` change on the edge after the command.
- `active` drops on the same edge where the STOP-state wrap occurs.
- Asynchronous reset mid-operation forces every register to its reset value immediately. The first post-reset `note_on` behaves as from IDLE.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN without a clock edge → `phase`=0, `gate`=0, `active`=0 and `table_idx`=0 immediately. Ticks after release give `phase_valid` pulses with `phase`=0.
- **Basic run:** `note_on` with `note_idx`=69 (step 167391), then 3 ticks → `phase` = 167391, 334782, 502173. `wrap`=0 throughout.
- **Release at wrap:** note 127 (step 4772129), 2 ticks (phase 9544258), `note_off` → `gate`=0. Tick → 14316387 in STOP. Next tick → carry, so `phase`=0, `wrap`=1 and state IDLE with `active`=0.
- **Glide:** `GLIDE_SHIFT`=2. Note 57 (step 83695), 1 tick. Retrigger to 69, then 1 tick → `cur_step`=104619 and `phase`=188314. Further ticks converge exactly to 167391 without overshoot.
- **Collisions:** `note_on` and `note_off` in the same cycle → RUN with `gate`=1. `note_off` in IDLE → no change.
- **Back-to-back ticks:** `sample_tick` high for 4 consecutive cycles → 4 `phase_valid` pulses with correct accumulation.
